// File: rtl/cam_lru_pkg.sv
// Shared types for the parametrised LRU CAM: request opcodes, flush FSM states
// and the statistics counter width.
package cam_lru_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_INVAL = 2'd2
  } cam_op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } cam_state_e;

  localparam int STAT_W = 32;

endpackage

// File: rtl/cam_age_tracker.sv
// Exact true-LRU age ranks for NUM_ENTRIES entries. Ages always form a permutation
// of 0..NUM_ENTRIES-1 (0 = most recently used); touch, demote and reinit keep it so.
module cam_age_tracker #(
  parameter int NUM_ENTRIES = 8,
  localparam int AW = $clog2(NUM_ENTRIES)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      touch_en,
  input  logic                      demote_en,
  input  logic [AW-1:0]             index,
  input  logic                      reinit,
  output logic [NUM_ENTRIES*AW-1:0] ages,
  output logic [AW-1:0]             lru_idx
);

  localparam logic [AW-1:0] AGE_MAX = AW'(NUM_ENTRIES - 1);

  logic [AW-1:0] tgt_age;

  assign tgt_age = ages[int'(index)*AW +: AW];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_age
      logic [AW-1:0] age_reg;

      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          age_reg <= AW'(gi);
        end else if (reinit) begin
          age_reg <= AW'(gi);
        end else if (touch_en) begin
          // Younger entries age by one so the permutation stays intact.
          if (index == AW'(gi))
            age_reg <= '0;
          else if (age_reg < tgt_age)
            age_reg <= age_reg + AW'(1);
        end else if (demote_en) begin
          if (index == AW'(gi))
            age_reg <= AGE_MAX;
          else if (age_reg > tgt_age)
            age_reg <= age_reg - AW'(1);
        end
      end

      assign ages[gi*AW +: AW] = age_reg;
    end
  endgenerate

  always_comb begin
    lru_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (ages[i*AW +: AW] == AGE_MAX)
        lru_idx = AW'(i);
    end
  end

endmodule

// File: rtl/cam_lru_param.sv
// Fully associative key/value CAM with true-LRU replacement, 1-cycle registered
// response, eviction reporting and a multi-cycle flush. Define CAM_STATS_EN for READ hit/miss counters.
module cam_lru_param
  import cam_lru_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int KEY_W       = 16,
  parameter int VAL_W       = 32
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [KEY_W-1:0] req_key_i,
  input  logic [VAL_W-1:0] req_val_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             resp_valid_o,
  output logic             resp_hit_o,
  output logic [VAL_W-1:0] resp_val_o,
  output logic             resp_evict_o,
  output logic [KEY_W-1:0] resp_evict_key_o,
  output logic [VAL_W-1:0] resp_evict_val_o
`ifdef CAM_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_hits_o,
  output logic [STAT_W-1:0] stat_misses_o
`endif
);

  localparam int AW = $clog2(NUM_ENTRIES);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_ENTRIES - 1);

  logic [NUM_ENTRIES-1:0]    valid_reg;
  logic [KEY_W-1:0]          key_mem [NUM_ENTRIES];
  logic [VAL_W-1:0]          val_mem [NUM_ENTRIES];
  cam_state_e                state_reg;
  logic [AW-1:0]             flush_ptr_reg;
  logic [NUM_ENTRIES*AW-1:0] age_flat;
  logic [AW-1:0]             lru_idx;

  logic [NUM_ENTRIES-1:0] hit_vec;
  logic                   hit_any;
  logic [AW-1:0]          hit_idx;
  logic                   free_any;
  logic [AW-1:0]          free_idx;
  cam_op_e                op;
  logic                   accept;
  logic                   do_read;
  logic                   do_write;
  logic                   do_inval;
  logic                   need_evict;
  logic [AW-1:0]          victim;
  logic                   touch_en;
  logic                   demote_en;
  logic [AW-1:0]          age_idx;
  logic                   flush_last;

  // Match lines
  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_match
      assign hit_vec[gi] = valid_reg[gi] & (key_mem[gi] == req_key_i);
    end
  endgenerate

  // Descending scan leaves the lowest matching / free index selected.
  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_any = 1'b1;
        hit_idx = AW'(i);
      end
      if (!valid_reg[i]) begin
        free_any = 1'b1;
        free_idx = AW'(i);
      end
    end
  end

  assign op          = cam_op_e'(req_op_i);
  assign req_ready_o = (state_reg == IDLE) & ~flush_i;
  assign busy_o      = (state_reg == FLUSH);
  assign accept      = req_valid_i & req_ready_o;
  assign do_read     = accept & (op == OP_READ);
  assign do_write    = accept & (op == OP_WRITE);
  assign do_inval    = accept & (op == OP_INVAL);
  assign need_evict  = ~hit_any & ~free_any;
  assign victim      = hit_any ? hit_idx : (free_any ? free_idx : lru_idx);
  assign touch_en    = (do_read & hit_any) | do_write;
  assign demote_en   = do_inval & hit_any;
  assign age_idx     = do_write ? victim : hit_idx;
  assign flush_last  = (state_reg == FLUSH) && (flush_ptr_reg == LAST_IDX);

  cam_age_tracker #(
    .NUM_ENTRIES(NUM_ENTRIES)
  ) u_age (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .touch_en  (touch_en),
    .demote_en (demote_en),
    .index     (age_idx),
    .reinit    (flush_last),
    .ages      (age_flat),
    .lru_idx   (lru_idx)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg     <= IDLE;
      flush_ptr_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (flush_i) begin
            state_reg     <= FLUSH;
            flush_ptr_reg <= '0;
          end
        end
        FLUSH: begin
          if (flush_ptr_reg == LAST_IDX)
            state_reg <= IDLE;
          else
            flush_ptr_reg <= flush_ptr_reg + AW'(1);
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_reg <= '0;
    end else if (state_reg == FLUSH) begin
      valid_reg[flush_ptr_reg] <= 1'b0;
    end else if (do_write) begin
      valid_reg[victim] <= 1'b1;
    end else if (demote_en) begin
      valid_reg[hit_idx] <= 1'b0;
    end
  end

  // Payload storage carries no reset; valid_reg alone qualifies it.
  always_ff @(posedge clk_i) begin
    if (do_write) begin
      key_mem[victim] <= req_key_i;
      val_mem[victim] <= req_val_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      resp_valid_o     <= 1'b0;
      resp_hit_o       <= 1'b0;
      resp_val_o       <= '0;
      resp_evict_o     <= 1'b0;
      resp_evict_key_o <= '0;
      resp_evict_val_o <= '0;
    end else begin
      resp_valid_o <= accept;
      if (accept) begin
        resp_hit_o <= hit_any;
        resp_val_o <= (do_read && hit_any) ? val_mem[hit_idx] : '0;
        if (do_write && need_evict) begin
          resp_evict_o     <= 1'b1;
          resp_evict_key_o <= key_mem[lru_idx];
          resp_evict_val_o <= val_mem[lru_idx];
        end else begin
          resp_evict_o     <= 1'b0;
          resp_evict_key_o <= '0;
          resp_evict_val_o <= '0;
        end
      end
    end
  end

`ifdef CAM_STATS_EN
  logic [STAT_W-1:0] hits_reg;
  logic [STAT_W-1:0] misses_reg;
  logic              flush_start;

  assign flush_start = (state_reg == IDLE) & flush_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hits_reg   <= '0;
      misses_reg <= '0;
    end else if (flush_start) begin
      hits_reg   <= '0;
      misses_reg <= '0;
    end else if (do_read) begin
      if (hit_any && hits_reg != '1)
        hits_reg <= hits_reg + STAT_W'(1);
      if (!hit_any && misses_reg != '1)
        misses_reg <= misses_reg + STAT_W'(1);
    end
  end

  assign stat_hits_o   = hits_reg;
  assign stat_misses_o = misses_reg;
`endif

endmodule

// File: tb/tb_cam_lru_param.sv
// Directed bench for cam_lru_param at NUM_ENTRIES=4, KEY_W=8, VAL_W=8; also checks
// the statistics ports when CAM_STATS_EN is defined.
module tb_cam_lru_param;
  import cam_lru_pkg::*;

  localparam int N  = 4;
  localparam int KW = 8;
  localparam int VW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [KW-1:0] req_key;
  logic [VW-1:0] req_val;
  logic          flush;
  logic          busy;
  logic          resp_valid;
  logic          resp_hit;
  logic [VW-1:0] resp_val;
  logic          resp_evict;
  logic [KW-1:0] resp_evict_key;
  logic [VW-1:0] resp_evict_val;
`ifdef CAM_STATS_EN
  logic [31:0]   stat_hits;
  logic [31:0]   stat_misses;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cam_lru_param #(.NUM_ENTRIES(N), .KEY_W(KW), .VAL_W(VW)) dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_op_i         (req_op),
    .req_key_i        (req_key),
    .req_val_i        (req_val),
    .flush_i          (flush),
    .busy_o           (busy),
    .resp_valid_o     (resp_valid),
    .resp_hit_o       (resp_hit),
    .resp_val_o       (resp_val),
    .resp_evict_o     (resp_evict),
    .resp_evict_key_o (resp_evict_key),
    .resp_evict_val_o (resp_evict_val)
`ifdef CAM_STATS_EN
    ,
    .stat_hits_o      (stat_hits),
    .stat_misses_o    (stat_misses)
`endif
  );

  // Expected age vector, entry 0 in the low bits.
  function automatic logic [7:0] pack_ages(input int a0, input int a1, input int a2, input int a3);
    return {2'(a3), 2'(a2), 2'(a1), 2'(a0)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    flush     = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One request; returns at the negedge where its response is visible.
  task automatic send(input logic [1:0] op, input logic [KW-1:0] k, input logic [VW-1:0] v);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_key   = k;
    req_val   = v;
    @(negedge clk);
    req_valid = 1'b0;
    $display("req op=%0d key=%h val=%h -> valid=%b hit=%b rval=%h evict=%b ekey=%h eval=%h",
             op, k, v, resp_valid, resp_hit, resp_val, resp_evict, resp_evict_key, resp_evict_val);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    n_cmp++; if (dut.valid_reg !== 4'b0000) begin n_bad++; $display("FAIL rst_valid got=%b exp=0000", dut.valid_reg); end
    n_cmp++; if (dut.age_flat !== pack_ages(0, 1, 2, 3)) begin n_bad++; $display("FAIL rst_ages got=%h exp=%h", dut.age_flat, pack_ages(0, 1, 2, 3)); end
    send(OP_READ, 8'h11, 8'h00);
    n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL rd0_valid got=%b exp=1", resp_valid); end
    n_cmp++; if (resp_hit !== 1'b0) begin n_bad++; $display("FAIL rd0_hit got=%b exp=0", resp_hit); end
    n_cmp++; if (resp_val !== 8'h00) begin n_bad++; $display("FAIL rd0_val got=%h exp=00", resp_val); end
    @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rd0_pulse got=%b exp=0", resp_valid); end
  endtask

  task automatic test_write_read();
    do_reset();
    send(OP_WRITE, 8'h11, 8'hA1);
    n_cmp++; if (resp_hit !== 1'b0 || resp_evict !== 1'b0) begin n_bad++; $display("FAIL wr_first got hit=%b evict=%b exp 0/0", resp_hit, resp_evict); end
    send(OP_READ, 8'h11, 8'h00);
    n_cmp++; if (resp_hit !== 1'b1) begin n_bad++; $display("FAIL wr_rd_hit got=%b exp=1", resp_hit); end
    n_cmp++; if (resp_val !== 8'hA1) begin n_bad++; $display("FAIL wr_rd_val got=%h exp=a1", resp_val); end
    n_cmp++; if (resp_evict !== 1'b0) begin n_bad++; $display("FAIL wr_rd_evict got=%b exp=0", resp_evict); end
    n_cmp++; if (dut.age_flat[1:0] !== 2'd0) begin n_bad++; $display("FAIL wr_rd_age0 got=%0d exp=0", dut.age_flat[1:0]); end
  endtask

  task automatic test_evict();
    do_reset();
    send(OP_WRITE, 8'h01, 8'h11);
    send(OP_WRITE, 8'h02, 8'h22);
    send(OP_WRITE, 8'h03, 8'h33);
    send(OP_WRITE, 8'h04, 8'h44);
    n_cmp++; if (dut.age_flat !== pack_ages(3, 2, 1, 0)) begin n_bad++; $display("FAIL fill_ages got=%h exp=%h", dut.age_flat, pack_ages(3, 2, 1, 0)); end
    send(OP_READ, 8'h01, 8'h00);
    n_cmp++; if (dut.age_flat !== pack_ages(0, 3, 2, 1)) begin n_bad++; $display("FAIL touch_ages got=%h exp=%h", dut.age_flat, pack_ages(0, 3, 2, 1)); end
    send(OP_WRITE, 8'h05, 8'h55);
    n_cmp++; if (resp_evict !== 1'b1) begin n_bad++; $display("FAIL ev_flag got=%b exp=1", resp_evict); end
    n_cmp++; if (resp_evict_key !== 8'h02) begin n_bad++; $display("FAIL ev_key got=%h exp=02", resp_evict_key); end
    n_cmp++; if (resp_evict_val !== 8'h22) begin n_bad++; $display("FAIL ev_val got=%h exp=22", resp_evict_val); end
    n_cmp++; if (resp_hit !== 1'b0) begin n_bad++; $display("FAIL ev_hit got=%b exp=0", resp_hit); end
    n_cmp++; if (dut.age_flat !== pack_ages(1, 0, 3, 2)) begin n_bad++; $display("FAIL ev_ages got=%h exp=%h", dut.age_flat, pack_ages(1, 0, 3, 2)); end
    send(OP_READ, 8'h02, 8'h00);
    n_cmp++; if (resp_hit !== 1'b0 || resp_val !== 8'h00) begin n_bad++; $display("FAIL ev_rd_old got hit=%b val=%h exp 0/00", resp_hit, resp_val); end
    send(OP_READ, 8'h05, 8'h00);
    n_cmp++; if (resp_hit !== 1'b1 || resp_val !== 8'h55) begin n_bad++; $display("FAIL ev_rd_new got hit=%b val=%h exp 1/55", resp_hit, resp_val); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(OP_WRITE, 8'h10, 8'hA0);
    send(OP_WRITE, 8'h20, 8'hB0);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_WRITE;
    req_key   = 8'h20;
    req_val   = 8'h2A;
    @(negedge clk);
    $display("req op=%0d key=20 val=2a -> valid=%b hit=%b evict=%b", OP_WRITE, resp_valid, resp_hit, resp_evict);
    n_cmp++; if (resp_valid !== 1'b1 || resp_hit !== 1'b1) begin n_bad++; $display("FAIL b2b_wr got valid=%b hit=%b exp 1/1", resp_valid, resp_hit); end
    n_cmp++; if (resp_evict !== 1'b0) begin n_bad++; $display("FAIL b2b_wr_evict got=%b exp=0", resp_evict); end
    req_op = OP_INVAL;
    @(negedge clk);
    req_valid = 1'b0;
    $display("req op=%0d key=20 -> valid=%b hit=%b", OP_INVAL, resp_valid, resp_hit);
    n_cmp++; if (resp_valid !== 1'b1 || resp_hit !== 1'b1) begin n_bad++; $display("FAIL b2b_inv got valid=%b hit=%b exp 1/1", resp_valid, resp_hit); end
    n_cmp++; if (dut.valid_reg !== 4'b0001) begin n_bad++; $display("FAIL b2b_valid got=%b exp=0001", dut.valid_reg); end
    n_cmp++; if (dut.age_flat !== pack_ages(0, 3, 1, 2)) begin n_bad++; $display("FAIL b2b_demote got=%h exp=%h", dut.age_flat, pack_ages(0, 3, 1, 2)); end
    send(OP_WRITE, 8'h30, 8'hC0);
    n_cmp++; if (resp_evict !== 1'b0 || resp_hit !== 1'b0) begin n_bad++; $display("FAIL refill got evict=%b hit=%b exp 0/0", resp_evict, resp_hit); end
    n_cmp++; if (dut.valid_reg !== 4'b0011) begin n_bad++; $display("FAIL refill_valid got=%b exp=0011", dut.valid_reg); end
    n_cmp++; if (dut.age_flat !== pack_ages(1, 0, 2, 3)) begin n_bad++; $display("FAIL refill_ages got=%h exp=%h", dut.age_flat, pack_ages(1, 0, 2, 3)); end
    send(OP_READ, 8'h30, 8'h00);
    n_cmp++; if (resp_hit !== 1'b1 || resp_val !== 8'hC0) begin n_bad++; $display("FAIL refill_rd got hit=%b val=%h exp 1/c0", resp_hit, resp_val); end
    send(OP_READ, 8'h20, 8'h00);
    n_cmp++; if (resp_hit !== 1'b0) begin n_bad++; $display("FAIL inv_rd got=%b exp=0", resp_hit); end
  endtask

  task automatic test_flush();
    int cnt;
    do_reset();
    for (int i = 1; i <= 4; i++) send(OP_WRITE, 8'(i), 8'(16 * i));
    @(negedge clk);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_op    = OP_READ;
    req_key   = 8'h01;
    #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL fl_ready got=%b exp=0", req_ready); end
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    $display("flush pulse -> resp_valid=%b busy=%b", resp_valid, busy);
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL fl_accept got=%b exp=0", resp_valid); end
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      cnt++;
      @(negedge clk);
    end
    n_cmp++; if (cnt != 4) begin n_bad++; $display("FAIL fl_busy_cycles got=%0d exp=4", cnt); end
    n_cmp++; if (dut.valid_reg !== 4'b0000) begin n_bad++; $display("FAIL fl_valid got=%b exp=0000", dut.valid_reg); end
    n_cmp++; if (dut.age_flat !== pack_ages(0, 1, 2, 3)) begin n_bad++; $display("FAIL fl_ages got=%h exp=%h", dut.age_flat, pack_ages(0, 1, 2, 3)); end
    for (int i = 1; i <= 4; i++) begin
      send(OP_READ, 8'(i), 8'h00);
      n_cmp++; if (resp_hit !== 1'b0 || resp_valid !== 1'b1) begin n_bad++; $display("FAIL fl_rd%0d got hit=%b valid=%b exp 0/1", i, resp_hit, resp_valid); end
    end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    send(OP_WRITE, 8'h01, 8'h11);
    send(OP_WRITE, 8'h02, 8'h22);
    send(OP_READ, 8'h01, 8'h00);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    $display("reset mid-flush -> busy=%b resp_valid=%b valid=%b", busy, resp_valid, dut.valid_reg);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mf_busy got=%b exp=0", busy); end
    n_cmp++; if (resp_valid !== 1'b0 || resp_hit !== 1'b0) begin n_bad++; $display("FAIL mf_resp got valid=%b hit=%b exp 0/0", resp_valid, resp_hit); end
    n_cmp++; if (dut.valid_reg !== 4'b0000) begin n_bad++; $display("FAIL mf_valid got=%b exp=0000", dut.valid_reg); end
`ifdef CAM_STATS_EN
    n_cmp++; if (stat_hits !== 32'd0 || stat_misses !== 32'd0) begin n_bad++; $display("FAIL mf_stats got=%0d/%0d exp 0/0", stat_hits, stat_misses); end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    send(OP_READ, 8'h02, 8'h00);
    n_cmp++; if (resp_hit !== 1'b0) begin n_bad++; $display("FAIL mf_rd got=%b exp=0", resp_hit); end
  endtask

`ifdef CAM_STATS_EN
  task automatic test_stats();
    do_reset();
    send(OP_WRITE, 8'h01, 8'h11);
    send(OP_READ, 8'h01, 8'h00);
    send(OP_READ, 8'h02, 8'h00);
    send(OP_READ, 8'h03, 8'h00);
    n_cmp++; if (stat_hits !== 32'd1) begin n_bad++; $display("FAIL st_hits got=%0d exp=1", stat_hits); end
    n_cmp++; if (stat_misses !== 32'd2) begin n_bad++; $display("FAIL st_misses got=%0d exp=2", stat_misses); end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++; if (stat_hits !== 32'd0 || stat_misses !== 32'd0) begin n_bad++; $display("FAIL st_flush got=%0d/%0d exp 0/0", stat_hits, stat_misses); end
    repeat (6) @(negedge clk);
  endtask
`endif

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'd0;
    req_key   = '0;
    req_val   = '0;
    flush     = 1'b0;
    test_reset();
    test_write_read();
    test_evict();
    test_back_to_back();
    test_flush();
    test_reset_mid_flush();
`ifdef CAM_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
